dsp_mac_pipe: RTL and testbench

DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

---
 rtl/dsp_mac_pipe.sv | 156 +++++++++++++++
 tb/tb_dsp_mac_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_pipe.sv
// Three-stage pipelined pre-add / multiply / post-add MAC with accumulator, global stall
// and optional saturation on overflow of the P_W-bit result.
module dsp_mac_pipe #(
  parameter int unsigned A_W      = 18,
  parameter int unsigned B_W      = 18,
  parameter int unsigned D_W      = 18,
  parameter int unsigned P_W      = 48,
  parameter bit          SATURATE = 1'b0
) (
  input  logic           clk,
  input  logic           RSTN,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] A,
  input  logic [B_W-1:0] B,
  input  logic [D_W-1:0] D,
  input  logic [P_W-1:0] C,
  input  logic [2:0]     MODE,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] P,
  output logic           OVF
);

  localparam int unsigned PaW = ((B_W > D_W) ? B_W : D_W) + 1;
  localparam int unsigned MW  = A_W + PaW;
  localparam logic [P_W-1:0] PMax = {1'b0, {(P_W-1){1'b1}}};
  localparam logic [P_W-1:0] PMin = {1'b1, {(P_W-1){1'b0}}};

  if (P_W < MW) begin : g_bad_p_w
    $error("dsp_mac_pipe: P_W must be at least A_W + max(B_W, D_W) + 1");
  end

  // Every stage advances together; a stalled output freezes the whole pipe.
  logic adv;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // S1: registered operands
  logic                  v1_q, v1_d;
  logic signed [A_W-1:0] a1_q, a1_d;
  logic signed [B_W-1:0] b1_q, b1_d;
  logic signed [D_W-1:0] d1_q, d1_d;
  logic signed [P_W-1:0] c1_q, c1_d;
  logic [2:0]            mode1_q, mode1_d;

  // S2: product, post-add operand and accumulate select
  logic                  v2_q, v2_d;
  logic signed [MW-1:0]  m2_q, m2_d;
  logic signed [P_W-1:0] c2_q, c2_d;
  logic                  acc_sel2_q, acc_sel2_d;

  // S3: result, flag and accumulator
  logic                  v3_q, v3_d;
  logic [P_W-1:0]        p_q, p_d;
  logic                  ovf_q, ovf_d;
  logic signed [P_W-1:0] acc_q, acc_d;

  logic signed [PaW-1:0] b_ext, d_ext, pa;
  logic signed [MW-1:0]  m_full;
  logic signed [P_W:0]   r;
  logic                  r_ovf;
  logic [P_W-1:0]        p_res;

  always_comb begin
    b_ext  = PaW'(b1_q);
    d_ext  = PaW'(d1_q);
    pa     = !mode1_q[0] ? b_ext : (mode1_q[1] ? d_ext - b_ext : d_ext + b_ext);
    m_full = MW'(a1_q) * MW'(pa);
  end

  // One guard bit above P_W exposes signed overflow of the post-add.
  always_comb begin
    r     = (P_W+1)'(acc_sel2_q ? acc_q : c2_q) + (P_W+1)'(m2_q);
    r_ovf = r[P_W] ^ r[P_W-1];
    if (r_ovf && SATURATE) begin
      p_res = r[P_W] ? PMin : PMax;
    end else begin
      p_res = r[P_W-1:0];
    end
  end

  always_comb begin
    v1_d       = v1_q;
    a1_d       = a1_q;
    b1_d       = b1_q;
    d1_d       = d1_q;
    c1_d       = c1_q;
    mode1_d    = mode1_q;
    v2_d       = v2_q;
    m2_d       = m2_q;
    c2_d       = c2_q;
    acc_sel2_d = acc_sel2_q;
    v3_d       = v3_q;
    p_d        = p_q;
    ovf_d      = ovf_q;
    acc_d      = acc_q;
    if (adv) begin
      v1_d       = in_valid;
      a1_d       = A;
      b1_d       = B;
      d1_d       = D;
      c1_d       = C;
      mode1_d    = MODE;
      v2_d       = v1_q;
      m2_d       = m_full;
      c2_d       = c1_q;
      acc_sel2_d = mode1_q[2];
      v3_d       = v2_q;
      if (v2_q) begin
        p_d   = p_res;
        ovf_d = r_ovf;
        acc_d = p_res;
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      v1_q       <= 1'b0;
      a1_q       <= '0;
      b1_q       <= '0;
      d1_q       <= '0;
      c1_q       <= '0;
      mode1_q    <= '0;
      v2_q       <= 1'b0;
      m2_q       <= '0;
      c2_q       <= '0;
      acc_sel2_q <= 1'b0;
      v3_q       <= 1'b0;
      p_q        <= '0;
      ovf_q      <= 1'b0;
      acc_q      <= '0;
    end else begin
      v1_q       <= v1_d;
      a1_q       <= a1_d;
      b1_q       <= b1_d;
      d1_q       <= d1_d;
      c1_q       <= c1_d;
      mode1_q    <= mode1_d;
      v2_q       <= v2_d;
      m2_q       <= m2_d;
      c2_q       <= c2_d;
      acc_sel2_q <= acc_sel2_d;
      v3_q       <= v3_d;
      p_q        <= p_d;
      ovf_q      <= ovf_d;
      acc_q      <= acc_d;
    end
  end

  assign out_valid = v3_q;
  assign P         = p_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Scoreboard bench for dsp_mac_pipe: a wrapping and a saturating instance share stimulus;
// expected results are pushed on acceptance and popped by an independent output monitor.
module tb_dsp_mac_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [17:0] a, b, d;
  logic [47:0] c;
  logic [2:0]  mode;
  logic        out_ready;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
  logic [47:0] p0, p1;

  always #5 clk = ~clk;

  dsp_mac_pipe #(.SATURATE(1'b0)) u_dut_wrap (
    .clk(clk), .RSTN(rstn), .in_valid(in_valid), .in_ready(in_ready0),
    .A(a), .B(b), .D(d), .C(c), .MODE(mode),
    .out_valid(out_valid0), .out_ready(out_ready), .P(p0), .OVF(ovf0)
  );

  dsp_mac_pipe #(.SATURATE(1'b1)) u_dut_sat (
    .clk(clk), .RSTN(rstn), .in_valid(in_valid), .in_ready(in_ready1),
    .A(a), .B(b), .D(d), .C(c), .MODE(mode),
    .out_valid(out_valid1), .out_ready(out_ready), .P(p1), .OVF(ovf1)
  );

  typedef struct {
    logic [47:0] p0;
    logic        ovf0;
    logic [47:0] p1;
    logic        ovf1;
    int          t_in;
    bit          chk_lat;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Presents one beat until accepted, then records the hand-computed expectation.
  task automatic issue(input logic [17:0] ia, input logic [17:0] ib, input logic [17:0] id,
                       input logic [47:0] ic, input logic [2:0] imode,
                       input logic [47:0] e0, input logic eo0,
                       input logic [47:0] e1, input logic eo1, input bit lat);
    bit took = 1'b0;
    int t = 0;
    in_valid = 1'b1;
    a = ia; b = ib; d = id; c = ic; mode = imode;
    for (int i = 0; i < 100 && !took; i++) begin
      @(negedge clk);
      took = in_ready0;
      t    = cyc;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!took) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got in_ready=0 want 1");
    end else begin
      sbq.push_back('{e0, eo0, e1, eo1, t, lat});
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && out_valid0 && out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got P=%0h want no output", p0);
        end else begin
          e = sbq.pop_front();
          check("p_wrap", 64'(p0), 64'(e.p0));
          check("ovf_wrap", 64'(ovf0), 64'(e.ovf0));
          check("p_sat", 64'(p1), 64'(e.p1));
          check("ovf_sat", 64'(ovf1), 64'(e.ovf1));
          check("valid_sat", 64'(out_valid1), 64'd1);
          if (e.chk_lat) check("latency", 64'(cyc - e.t_in), 64'd3);
        end
      end
    end
  end

  initial begin : stim
    rstn      = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a = 18'($urandom); b = 18'($urandom); d = 18'($urandom);
    c = {16'($urandom), 32'($urandom)}; mode = 3'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_p", 64'(p0), 64'd0);
    check("rst_ovf", 64'(ovf0), 64'd0);
    check("rst_out_valid", 64'(out_valid0), 64'd0);
    check("rst_in_ready", 64'(in_ready0), 64'd1);
    check("rst_p_sat", 64'(p1), 64'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;

    // Pre-add and pre-subtract
    issue(18'd20, 18'd10, 18'd25, 48'd350, 3'b001, 48'd1050, 1'b0, 48'd1050, 1'b0, 1'b1);
    issue(18'd20, 18'd10, 18'd25, 48'd350, 3'b011, 48'd650, 1'b0, 48'd650, 1'b0, 1'b1);

    // Accumulate chain back-to-back
    issue(18'd5, 18'd6, 18'd0, 48'd0, 3'b000, 48'd30, 1'b0, 48'd30, 1'b0, 1'b1);
    issue(18'd5, 18'd6, 18'd0, 48'd0, 3'b100, 48'd60, 1'b0, 48'd60, 1'b0, 1'b1);
    issue(18'd5, 18'd6, 18'd0, 48'd0, 3'b100, 48'd90, 1'b0, 48'd90, 1'b0, 1'b1);
    issue(18'd5, 18'd6, 18'd0, 48'd0, 3'b100, 48'd120, 1'b0, 48'd120, 1'b0, 1'b1);

    // Signed operands: (-2-7)*-3 + -100 = -73, then acc + (-2+7)*-3 = -88
    issue(-18'sd3, 18'd7, -18'sd2, -48'sd100, 3'b011,
          -48'sd73, 1'b0, -48'sd73, 1'b0, 1'b0);
    issue(-18'sd3, 18'd7, -18'sd2, 48'd0, 3'b101,
          -48'sd88, 1'b0, -48'sd88, 1'b0, 1'b0);

    // Positive and negative overflow, then accumulate from the stored P
    issue(18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 3'b000,
          48'h8000_0000_0000, 1'b1, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b0);
    issue(-18'sd1, 18'd1, 18'd0, 48'h8000_0000_0000, 3'b000,
          48'h7FFF_FFFF_FFFF, 1'b1, 48'h8000_0000_0000, 1'b1, 1'b0);
    issue(18'd0, 18'd0, 18'd0, 48'd0, 3'b100,
          48'h7FFF_FFFF_FFFF, 1'b0, 48'h8000_0000_0000, 1'b0, 1'b0);

    // Bubbles between beats must leave ACC untouched
    issue(18'd2, 18'd2, 18'd0, 48'd1, 3'b000, 48'd5, 1'b0, 48'd5, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    issue(18'd1, 18'd1, 18'd0, 48'd0, 3'b100, 48'd6, 1'b0, 48'd6, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;

    // Output stall with beats queued behind it
    fork
      begin
        for (int k = 1; k <= 4; k++) begin
          issue(18'(k), 18'd10, 18'd0, 48'd0, 3'b000,
                48'(k * 10), 1'b0, 48'(k * 10), 1'b0, 1'b0);
        end
      end
      begin
        for (int i = 0; i < 30 && !out_valid0; i++) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready0), 64'd0);
          check("stall_valid", 64'(out_valid0), 64'd1);
          check("stall_hold_p", 64'(p0), 64'd20);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Reset with two beats in flight; they must never appear
    issue(18'd7, 18'd7, 18'd0, 48'd0, 3'b100, 48'd0, 1'b0, 48'd0, 1'b0, 1'b0);
    issue(18'd7, 18'd7, 18'd0, 48'd0, 3'b100, 48'd0, 1'b0, 48'd0, 1'b0, 1'b0);
    rstn = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready0), 64'd1);
    check("midrst_out_valid", 64'(out_valid0), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", 64'(out_valid0), 64'd0);
    end
    @(posedge clk);
    #1;
    issue(18'd2, 18'd3, 18'd0, 48'd0, 3'b100, 48'd6, 1'b0, 48'd6, 1'b0, 1'b1);

    for (int i = 0; i < 50 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
